// File: rtl/ras_pkg.sv
// Shared constants and types for the return-address-stack controller and its call/return decoder.
package ras_pkg;

  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [4:0] LINK_X1  = 5'd1;
  localparam logic [4:0] LINK_X5  = 5'd5;

  typedef enum logic [1:0] {
    NONE,
    PUSH,
    POP,
    POP_PUSH
  } ras_op_t;

  typedef enum logic {
    IDLE,
    SECOND
  } ras_state_t;

  function automatic logic is_link(input logic [4:0] r);
    return (r == LINK_X1) || (r == LINK_X5);
  endfunction

endpackage

// File: rtl/ras_call_decode.sv
// Combinational call/return classifier using the RISC-V link-register hints.
// Optional RV32C classification is enabled by defining RAS_CTRL_COMPRESSED_EN.
module ras_call_decode
  import ras_pkg::*;
(
  input  logic [31:0] instr,
  output ras_op_t     op,
  output logic [2:0]  ret_off
);

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic       rd_l;
  logic       rs1_l;
  logic       unused_imm;

  assign opcode     = instr[6:0];
  assign rd         = instr[11:7];
  assign rs1        = instr[19:15];
  assign rd_l       = is_link(rd);
  assign rs1_l      = is_link(rs1);
  assign unused_imm = ^{instr[31:20], instr[14:12]};

  always_comb begin
    op      = NONE;
    ret_off = 3'd4;
    if (instr[1:0] == 2'b11) begin
      if (opcode == OPC_JAL) begin
        op = rd_l ? PUSH : NONE;
      end else if (opcode == OPC_JALR) begin
        case ({rd_l, rs1_l})
          2'b01:   op = POP;
          2'b10:   op = PUSH;
          2'b11:   op = (rd == rs1) ? PUSH : POP_PUSH;
          default: op = NONE;
        endcase
      end
    end
`ifdef RAS_CTRL_COMPRESSED_EN
    else begin
      ret_off = 3'd2;
      if (instr[1:0] == 2'b01 && instr[15:13] == 3'b001) begin
        op = PUSH;  // C.JAL implicitly links x1
      end else if (instr[1:0] == 2'b10 && instr[15:13] == 3'b100 &&
                   instr[6:2] == 5'd0 && rd != 5'd0) begin
        // rd field holds rs1 here; C.JALR links x1, C.JR does not link
        if (instr[12]) begin
          op = (rd == LINK_X5) ? POP_PUSH : PUSH;
        end else if (rd_l) begin
          op = POP;
        end
      end
    end
`endif
  end

endmodule

// File: rtl/ras_ctrl.sv
// Fetch-side RAS controller: registered push/pop pulses, occupancy tracking, return-target prediction.
// Define RAS_CTRL_COMPRESSED_EN to also classify RV32C calls/returns (handled in ras_call_decode).
module ras_ctrl
  import ras_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_instr,
  input  logic            flush,
  output logic            ras_push,
  output logic            ras_pop,
  output logic [XLEN-1:0] ras_pc_in,
  input  logic [XLEN-1:0] ras_pc_out,
  output logic            pred_valid,
  output logic [XLEN-1:0] pred_target
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  ras_op_t         op;
  logic [2:0]      ret_off;
  logic [XLEN-1:0] ret;

  ras_state_t      state_reg, state_next;
  logic [CW-1:0]   count_reg, count_next;
  logic            push_reg, push_next;
  logic            pop_reg, pop_next;
  logic [XLEN-1:0] ret_reg, ret_next;
  logic [XLEN-1:0] pc_in_reg, pc_in_next;

  ras_call_decode u_decode (
    .instr   (in_instr),
    .op      (op),
    .ret_off (ret_off)
  );

  assign ret = in_pc + XLEN'(ret_off);

  always_comb begin
    state_next = state_reg;
    push_next  = 1'b0;
    pop_next   = 1'b0;
    ret_next   = ret_reg;
    pc_in_next = pc_in_reg;
    count_next = count_reg;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            ret_next = ret;
            case (op)
              PUSH: begin
                push_next  = 1'b1;
                pc_in_next = ret;
              end
              POP:      pop_next = (count_reg != '0);
              POP_PUSH: begin
                pop_next   = (count_reg != '0);
                state_next = SECOND;
              end
              default: ;
            endcase
          end
        end
        SECOND: begin
          push_next  = 1'b1;
          pc_in_next = ret_reg;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
    // Count tracks pulses as they are committed; the stack overwrites when full.
    if (push_next && count_reg != FULL) begin
      count_next = count_reg + 1'b1;
    end else if (pop_next) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      count_reg <= '0;
      push_reg  <= 1'b0;
      pop_reg   <= 1'b0;
      ret_reg   <= '0;
      pc_in_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      push_reg  <= push_next;
      pop_reg   <= pop_next;
      ret_reg   <= ret_next;
      pc_in_reg <= pc_in_next;
    end
  end

  assign in_ready    = reset_n && (state_reg == IDLE);
  assign ras_push    = push_reg;
  assign ras_pop     = pop_reg;
  assign ras_pc_in   = pc_in_reg;
  assign pred_valid  = pop_reg;
  assign pred_target = pop_reg ? ras_pc_out : '0;

endmodule

// File: tb/tb_ras_ctrl.sv
// Scoreboard bench for ras_ctrl: stimulus queues expected push/pop pulses, a negedge monitor checks them.
module tb_ras_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic        flush = 1'b0;
  logic        ras_push;
  logic        ras_pop;
  logic [31:0] ras_pc_in;
  logic [31:0] ras_pc_out = '0;
  logic        pred_valid;
  logic [31:0] pred_target;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        is_push;
    logic [31:0] pc;
  } exp_t;
  exp_t q[$];

  ras_ctrl #(.DEPTH(32), .XLEN(32)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_instr    (in_instr),
    .flush       (flush),
    .ras_push    (ras_push),
    .ras_pop     (ras_pop),
    .ras_pc_in   (ras_pc_in),
    .ras_pc_out  (ras_pc_out),
    .pred_valid  (pred_valid),
    .pred_target (pred_target)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] jal(input logic [4:0] rd);
    return {20'd0, rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] jalr(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd0, rs1, 3'b000, rd, 7'b1100111};
  endfunction

  task automatic exp_push(input logic [31:0] pc);
    exp_t e;
    e.is_push = 1'b1;
    e.pc      = pc;
    q.push_back(e);
  endtask

  task automatic exp_pop(input logic [31:0] target);
    exp_t e;
    e.is_push = 1'b0;
    e.pc      = target;
    q.push_back(e);
  endtask

  // Presents one instruction for exactly one edge; returns #1 after that edge.
  task automatic send(input string name, input logic [31:0] instr, input logic [31:0] pc);
    chk({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    $display("sent %s instr=%h pc=%h", name, instr, pc);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      exp_t e;
      chk("pred_valid_eq_pop", {31'd0, pred_valid}, {31'd0, ras_pop});
      if (!pred_valid) chk("pred_target_idle", pred_target, 32'd0);
      if (ras_push && ras_pop) begin
        checks++;
        errors++;
        $display("FAIL push_pop_overlap: got push=1 pop=1 expected exclusive");
      end else if (ras_push || ras_pop) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: got push=%0b pop=%0b pc_in=%h expected none",
                   ras_push, ras_pop, ras_pc_in);
        end else begin
          e = q.pop_front();
          if (e.is_push) begin
            chk("push_pulse", {31'd0, ras_push}, 32'd1);
            chk("push_pc_in", ras_pc_in, e.pc);
            $display("push pc_in=%h expected %h", ras_pc_in, e.pc);
          end else begin
            chk("pop_pulse", {31'd0, ras_pop}, 32'd1);
            chk("pred_target", pred_target, e.pc);
            $display("pop pred_target=%h expected %h", pred_target, e.pc);
          end
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
    chk("reset_push", {31'd0, ras_push}, 32'd0);
    chk("reset_pop", {31'd0, ras_pop}, 32'd0);
    chk("reset_pred_valid", {31'd0, pred_valid}, 32'd0);
    chk("reset_pc_in", ras_pc_in, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(1);

    // T1: call pushes pc+4
    exp_push(32'h104);
    send("t1_jal_x1", jal(5'd1), 32'h100);
    // T2: return pops and predicts from stack output
    ras_pc_out = 32'h104;
    exp_pop(32'h104);
    send("t2_ret", jalr(5'd0, 5'd1), 32'h180);
    idle(1);
    // T3: return on empty stack is suppressed
    send("t3_ret_empty", jalr(5'd0, 5'd1), 32'h190);
    idle(1);
    chk("t3_in_ready", {31'd0, in_ready}, 32'd1);

    // T4: pop-then-push on count=1
    exp_push(32'h1F4);
    send("t4_jal", jal(5'd1), 32'h1F0);
    ras_pc_out = 32'h1F4;
    exp_pop(32'h1F4);
    exp_push(32'h204);
    send("t4_jalr_x1_x5", jalr(5'd1, 5'd5), 32'h200);
    chk("t4_busy", {31'd0, in_ready}, 32'd0);
    idle(2);
    chk("t4_ready_n3", {31'd0, in_ready}, 32'd1);

    // T5: flush in the SECOND cycle drops the pending push (count is 1 here)
    ras_pc_out = 32'h204;
    exp_pop(32'h204);
    send("t5_jalr_x1_x5", jalr(5'd1, 5'd5), 32'h300);
    chk("t5_busy", {31'd0, in_ready}, 32'd0);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("t5_ready_n2", {31'd0, in_ready}, 32'd1);
    idle(2);

    // Encoding boundaries, count is 0 here
    exp_push(32'h404);
    send("jalr_x1_x1_push", jalr(5'd1, 5'd1), 32'h400);
    send("jalr_x0_x2_none", jalr(5'd0, 5'd2), 32'h408);
    send("jal_x0_none", jal(5'd0), 32'h40C);
    send("addi_x1_none", {12'd0, 5'd0, 3'b000, 5'd1, 7'b0010011}, 32'h410);
    send("c_jalr_16b_none", 32'h0000_9082, 32'h414);
    ras_pc_out = 32'h404;
    exp_pop(32'h404);
    send("jalr_x0_x5_pop", jalr(5'd0, 5'd5), 32'h418);
    idle(1);
    exp_push(32'h0000_0000);
    send("jal_wrap", jal(5'd1), 32'hFFFF_FFFC);
    ras_pc_out = 32'h0;
    exp_pop(32'h0);
    send("ret_wrap", jalr(5'd0, 5'd1), 32'h500);
    idle(1);

    // T6: 33 calls saturate count at 32, so only 32 of 33 returns pop
    for (int i = 0; i < 33; i++) begin
      exp_push(32'h1004 + 32'(4 * i));
      send("t6_call", jal(5'd5), 32'h1000 + 32'(4 * i));
    end
    ras_pc_out = 32'hABC;
    for (int i = 0; i < 33; i++) begin
      if (i < 32) exp_pop(32'hABC);
      send("t6_ret", jalr(5'd0, 5'd5), 32'h2000);
    end
    idle(3);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
